aes128_encrypt_iter: RTL and testbench

Iterative AES-128 encryptor (FIPS-197) that computes one round per clock and expands the key on the fly. It accepts a plaintext/cipher-key pair over a valid/ready handshake. It returns the ciphertext together with the round-10 key, so its output pair drives the `ciphertext`/`key10` inputs of the team's pipelined AES-128 decryptor directly. It is the producer side of that decryptor: it generates the bench and loopback stimulus in place of pre-computed cipher files.

---
 rtl/aes128_encrypt_iter.sv | 185 ++++++++++++++++++
 tb/tb_aes128_encrypt_iter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, key expanded on the fly.
// Returns the ciphertext with the round-10 key so the pair feeds a decryptor directly.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   plaintext/key valid this cycle
//   in_ready   block idle and able to accept
//   plaintext  input block, byte 0 in [127:120], column-major state
//   key        cipher key, same byte order
//   out_valid  ciphertext/key10 valid
//   out_ready  consumer accepts the output this cycle
//   ciphertext encrypted block (registered)
//   key10      round-10 expanded key (registered)
//   busy       high while running or holding a result
module aes128_encrypt_iter #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic [127:0] key10,
    output logic         busy
);

    generate
        if (NUM_ROUNDS != 10) begin : g_bad_rounds
            $error("aes128_encrypt_iter: only NUM_ROUNDS = 10 is supported");
        end
    endgenerate

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[8 * (255 - int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [1:0]   fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rcnt_q, rcnt_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] key10_q, key10_d;
    logic         out_valid_q, out_valid_d;

    logic [127:0] sub_shift, mixed, rk_next;
    logic [31:0]  w3, key_sub, w0n, w1n, w2n, w3n;

    // SubBytes and ShiftRows fused: output (row r, col c) takes input (r, (c + r) mod 4).
    always_comb begin : round_datapath
        sub_shift = '0;
        mixed     = '0;
        for (int i = 0; i < 16; i++) begin
            sub_shift[127 - 8*i -: 8] =
                sbox(state_q[127 - 8*(4*(((i/4) + (i%4)) % 4) + (i%4)) -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32*c -: 32] = mix_column(sub_shift[127 - 32*c -: 32]);
        end
    end

    assign w3      = rk_q[31:0];
    assign key_sub = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    assign w0n     = rk_q[127:96] ^ key_sub ^ {rcon(rcnt_q), 24'h000000};
    assign w1n     = rk_q[95:64] ^ w0n;
    assign w2n     = rk_q[63:32] ^ w1n;
    assign w3n     = rk_q[31:0] ^ w2n;
    assign rk_next = {w0n, w1n, w2n, w3n};

    always_comb begin : next_state
        fsm_d       = fsm_q;
        state_d     = state_q;
        rk_d        = rk_q;
        rcnt_d      = rcnt_q;
        ct_d        = ct_q;
        key10_d     = key10_q;
        out_valid_d = out_valid_q;
        case (fsm_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = plaintext ^ key;
                    rk_d    = key;
                    rcnt_d  = 4'd1;
                    fsm_d   = StRun;
                end
            end
            StRun: begin
                if (rcnt_q == 4'd10) begin
                    // Final round skips MixColumns; rcnt parks at 10 until the next accept.
                    ct_d        = sub_shift ^ rk_next;
                    key10_d     = rk_next;
                    out_valid_d = 1'b1;
                    fsm_d       = StDone;
                end else begin
                    state_d = mixed ^ rk_next;
                    rk_d    = rk_next;
                    rcnt_d  = rcnt_q + 4'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q       <= StIdle;
            state_q     <= '0;
            rk_q        <= '0;
            rcnt_q      <= '0;
            ct_q        <= '0;
            key10_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            rk_q        <= rk_d;
            rcnt_q      <= rcnt_d;
            ct_q        <= ct_d;
            key10_q     <= key10_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = (fsm_q == StIdle);
    assign busy       = (fsm_q != StIdle);
    assign out_valid  = out_valid_q;
    assign ciphertext = ct_q;
    assign key10      = key10_q;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Scoreboard bench for aes128_encrypt_iter. Expected results come from a textbook AES model
// whose S-box is derived from GF(2^8) inversion; results are also decrypted back to plaintext.
module tb_aes128_encrypt_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] ciphertext, key10;

    aes128_encrypt_iter #(.NUM_ROUNDS(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .key10      (key10),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb [256];
    logic [7:0] isb [256];
    logic [7:0] rc_tab [11];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic model_init();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a, v;
            a = 8'(i);
            v = 8'h00;
            if (a != 8'h00)
                for (int j = 1; j < 256; j++)
                    if (gmul(a, 8'(j)) == 8'h01) v = 8'(j);
            sb[i] = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
        end
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
        rc_tab[0] = 8'h00;
        rc_tab[1] = 8'h01;
        for (int j = 2; j <= 10; j++) rc_tab[j] = gmul(rc_tab[j-1], 8'h02);
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    function automatic logic [31:0] sched_t(input logic [31:0] prev, input int i);
        if (i % 4 == 0) return sub_word({prev[23:0], prev[31:24]}) ^ {rc_tab[i/4], 24'h0};
        return prev;
    endfunction

    function automatic logic [127:0] fwd_round_key(input logic [127:0] k, input int n);
        logic [31:0] w [44];
        {w[0], w[1], w[2], w[3]} = k;
        for (int i = 4; i < 44; i++) w[i] = w[i-4] ^ sched_t(w[i-1], i);
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    // Walks the schedule backwards from the last round key.
    function automatic logic [127:0] rev_round_key(input logic [127:0] k10, input int n);
        logic [31:0] w [44];
        {w[40], w[41], w[42], w[43]} = k10;
        for (int i = 39; i >= 0; i--) w[i] = w[i+4] ^ sched_t(w[i+3], i + 4);
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    function automatic logic [127:0] sub_all(input logic [127:0] x, input bit inv);
        for (int i = 0; i < 16; i++)
            x[127 - 8*i -: 8] = inv ? isb[x[127 - 8*i -: 8]] : sb[x[127 - 8*i -: 8]];
        return x;
    endfunction

    function automatic logic [127:0] shift_all(input logic [127:0] x, input bit inv);
        logic [127:0] y;
        y = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                int sc;
                sc = inv ? (c - r + 4) % 4 : (c + r) % 4;
                y[127 - 8*(4*c + r) -: 8] = x[127 - 8*(4*sc + r) -: 8];
            end
        return y;
    endfunction

    function automatic logic [127:0] mix_all(input logic [127:0] x, input bit inv);
        logic [7:0]   m [4];
        logic [127:0] y;
        logic [7:0]   acc;
        if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
        y = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(m[(k - r + 4) % 4], x[127 - 8*(4*c + k) -: 8]);
                y[127 - 8*(4*c + r) -: 8] = acc;
            end
        return y;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] s;
        s = pt ^ fwd_round_key(k, 0);
        for (int r = 1; r <= 10; r++) begin
            s = shift_all(sub_all(s, 1'b0), 1'b0);
            if (r < 10) s = mix_all(s, 1'b0);
            s ^= fwd_round_key(k, r);
        end
        return s;
    endfunction

    function automatic logic [127:0] aes_decrypt(input logic [127:0] ct, input logic [127:0] k10);
        logic [127:0] s;
        s = ct ^ rev_round_key(k10, 10);
        for (int r = 9; r >= 0; r--) begin
            s = sub_all(shift_all(s, 1'b1), 1'b1);
            s ^= rev_round_key(k10, r);
            if (r > 0) s = mix_all(s, 1'b1);
        end
        return s;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [127:0] pt;
        logic [127:0] ct;
        logic [127:0] k10;
        int           acc_edge;
    } exp_t;

    exp_t exp_q[$];
    int   n_acc = 0;
    int   last_acc = -1;
    bit   streaming = 1'b0;
    bit   prev_ov = 1'b0;

    // Inputs are stable at the falling edge, so an accept here happens on the next rising edge.
    always @(negedge clk) begin : accept_mon
        exp_t e;
        if (rst && in_valid && in_ready) begin
            e.pt       = plaintext;
            e.ct       = aes_encrypt(plaintext, key);
            e.k10      = fwd_round_key(key, 10);
            e.acc_edge = edges + 1;
            if (streaming && last_acc >= 0)
                check("stream_interval", 128'(edges + 1 - last_acc), 128'd12);
            last_acc = edges + 1;
            exp_q.push_back(e);
            n_acc++;
        end
    end

    always @(negedge clk) begin : output_mon
        if (!rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 128'(out_valid), 128'd0);
                end else begin
                    if (!prev_ov) check("latency", 128'(edges - exp_q[0].acc_edge), 128'd10);
                    check("ciphertext", ciphertext, exp_q[0].ct);
                    check("key10", key10, exp_q[0].k10);
                    check("in_ready_done", 128'(in_ready), 128'd0);
                    check("busy_done", 128'(busy), 128'd1);
                    if (out_ready) begin
                        check("loopback_pt", aes_decrypt(ciphertext, key10), exp_q[0].pt);
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_out(input string name);
        for (int i = 0; i < 30 && !out_valid; i++) step();
        check({name, "_timeout"}, 128'(out_valid), 128'd1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) step();
        check({name, "_drain"}, 128'(exp_q.size()), 128'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_out_valid"}, 128'(out_valid), 128'd0);
        check({name, "_ct"}, ciphertext, 128'd0);
        check({name, "_key10"}, key10, 128'd0);
        check({name, "_in_ready"}, 128'(in_ready), 128'd1);
        check({name, "_busy"}, 128'(busy), 128'd0);
    endtask

    task automatic run_known(input string name, input logic [127:0] pt, input logic [127:0] k,
                             input logic [127:0] ect, input logic [127:0] ek10);
        out_ready = 1'b1;
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(name);
        check({name, "_ct"}, ciphertext, ect);
        check({name, "_key10"}, key10, ek10);
        step();
    endtask

    localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    initial begin : main
        int acc0;
        model_init();

        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b1;
        step();

        run_known("fips_c1", C1Pt, C1Key, C1Ct, C1K10);
        run_known("fips_b", 128'h3243f6a8885a308d313198a2e0370734,
                  128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32,
                  128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Backpressure with a second block offered while busy.
        out_ready = 1'b0;
        plaintext = rand128();
        key       = rand128();
        in_valid  = 1'b1;
        step();
        acc0      = n_acc;
        plaintext = rand128();
        for (int i = 0; i < 30 && !out_valid; i++) begin
            in_valid = i[0];
            check("bp_run_in_ready", 128'(in_ready), 128'd0);
            check("bp_run_busy", 128'(busy), 128'd1);
            step();
        end
        check("bp_done_timeout", 128'(out_valid), 128'd1);
        for (int i = 0; i < 7; i++) begin
            in_valid = (i % 2 == 0);
            check("bp_hold_in_ready", 128'(in_ready), 128'd0);
            step();
        end
        check("bp_no_accept", 128'(n_acc), 128'(acc0));
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        check("bp_handshake_no_accept", 128'(n_acc), 128'(acc0));
        check("bp_ready_after", 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;
        check("bp_reaccept", 128'(n_acc), 128'(acc0 + 1));
        drain("bp");

        // Reset in the middle of a block.
        plaintext = rand128();
        key       = rand128();
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("midrst");
        step();
        step();
        check_reset_outputs("midrst_hold");
        rst = 1'b1;
        step();
        run_known("post_reset_c1", C1Pt, C1Key, C1Ct, C1K10);

        // Free-running stream with both handshakes held high.
        streaming = 1'b1;
        last_acc  = -1;
        acc0      = n_acc;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 24 * 12 + 30; i++) begin
            plaintext = rand128();
            key       = rand128();
            step();
            if (n_acc - acc0 >= 24) break;
        end
        in_valid  = 1'b0;
        streaming = 1'b0;
        check("stream_count", 128'(n_acc - acc0), 128'd24);
        drain("stream");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
